// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the 4x4 matrix-keypad scanner:
//   - state_e      : scanner FSM states (SCAN, DEBOUNCE, HELD)
//   - COL_IDLE     : column pattern seen when no key is pressed
//   - rowDrive()   : one-cold active-low row drive for a row index
//   - patValid()   : true when exactly one column line is pulled low
//   - colIndex()   : position of the single low column line
//   - keyMap()     : hex code for a (row, column) key position
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_e;

    localparam logic [3:0] COL_IDLE = 4'b1111;

    // Key codes packed as nibbles, index {row, col}; nibble 0 is row 0 col 0.
    // Rows read left to right: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D.
    localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

    function automatic logic [3:0] rowDrive(input logic [1:0] r);
        logic [3:0] drive;
        case (r)
            2'd0:    drive = 4'b1110;
            2'd1:    drive = 4'b1101;
            2'd2:    drive = 4'b1011;
            default: drive = 4'b0111;
        endcase
        return drive;
    endfunction

    function automatic logic patValid(input logic [3:0] cols);
        logic ok;
        case (cols)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [1:0] colIndex(input logic [3:0] cols);
        logic [1:0] idx;
        case (cols)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] keyMap(input logic [1:0] r, input logic [1:0] c);
        logic [5:0] base;
        base = {r, c, 2'b00};
        return KEY_MAP[base +: 4];
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for a bus of independent level signals that are
// asynchronous to clk. Resets to all-ones so that idle (pulled-up) inputs
// look inactive while reset is applied.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   d_i      : asynchronous input bus
//   q_o      : synchronized copy of d_i, two clk cycles late
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // First stage may go metastable; second stage gives it a full cycle
    // to resolve before anything downstream looks at it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 matrix keypad one active-low row at a time, debounces a
// single pressed key and reports its hex code.
//   clk       : system clock
//   reset_n   : asynchronous active-low reset
//   col_n     : keypad columns, active-low, asynchronous to clk
//   row_n     : one-cold active-low row drive
//   key_code  : hex code of the last accepted key, held until the next one
//   key_valid : one-cycle pulse when a press is accepted
//   key_down  : high from accept until the release is accepted
// Parameters:
//   DIV_BITS  : row dwell is 2^DIV_BITS cycles (3..24)
//   DEB_CNT   : matching samples needed for press and for release (1..15)
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int DIV_BITS = 16,
    parameter int DEB_CNT  = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam logic [3:0] DEB_TARGET = 4'(DEB_CNT);

    logic [3:0]          colS;
    logic [DIV_BITS-1:0] cnt_q;
    logic [DIV_BITS-1:0] cnt_d;
    logic                samplePoint;

    state_e     state_q;
    logic [1:0] row_q;
    logic [3:0] pat_q;
    logic [3:0] deb_q;
    logic [3:0] deb_d;
    logic [3:0] rel_q;
    logic [3:0] rel_d;
    logic [3:0] code_q;
    logic       valid_q;
    logic       down_q;
    logic       doAccept;

    sync_2ff #(
        .WIDTH (4)
    ) u_colSync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (col_n),
        .q_o     (colS)
    );

    // Dwell counter runs in every state; its all-ones cycle is the only
    // moment the FSM looks at the columns, long after the row change has
    // propagated through the synchronizer.
    assign cnt_d       = cnt_q + DIV_BITS'(1);
    assign samplePoint = &cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Candidate debounce/release counts for this sample point.
    assign deb_d = deb_q + 4'd1;
    assign rel_d = rel_q + 4'd1;

    // A press is accepted either on first sight when one sample suffices,
    // or when the debounce count reaches its target on an unchanged pattern.
    always_comb begin
        doAccept = 1'b0;
        if (samplePoint) begin
            if (state_q == SCAN) begin
                doAccept = patValid(colS) && (DEB_TARGET == 4'd1);
            end else if (state_q == DEBOUNCE) begin
                doAccept = (colS == pat_q) && (deb_d == DEB_TARGET);
            end
        end
    end

    // Scanner FSM with registered outputs. The row index stays frozen from
    // first detection until the key is released (or the debounce fails),
    // so only the detected key's row is driven meanwhile.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SCAN;
            row_q   <= 2'd0;
            pat_q   <= COL_IDLE;
            deb_q   <= 4'd0;
            rel_q   <= 4'd0;
            code_q  <= 4'h0;
            valid_q <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            valid_q <= doAccept;
            if (doAccept) begin
                code_q  <= keyMap(row_q, colIndex(colS));
                down_q  <= 1'b1;
                rel_q   <= 4'd0;
                state_q <= HELD;
                if (state_q == SCAN) begin
                    pat_q <= colS;
                    deb_q <= 4'd1;
                end else begin
                    deb_q <= deb_d;
                end
            end else if (samplePoint) begin
                unique case (state_q)
                    SCAN: begin
                        if (patValid(colS)) begin
                            pat_q   <= colS;
                            deb_q   <= 4'd1;
                            state_q <= DEBOUNCE;
                        end else begin
                            row_q <= row_q + 2'd1;
                        end
                    end
                    DEBOUNCE: begin
                        if (colS == pat_q) begin
                            deb_q <= deb_d;
                        end else begin
                            deb_q   <= 4'd0;
                            row_q   <= row_q + 2'd1;
                            state_q <= SCAN;
                        end
                    end
                    HELD: begin
                        if (colS == COL_IDLE) begin
                            rel_q <= rel_d;
                            if (rel_d == DEB_TARGET) begin
                                down_q  <= 1'b0;
                                row_q   <= row_q + 2'd1;
                                state_q <= SCAN;
                            end
                        end else begin
                            rel_q <= 4'd0;
                        end
                    end
                    default: begin
                        state_q <= SCAN;
                    end
                endcase
            end
        end
    end

    assign row_n     = rowDrive(row_q);
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_down  = down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Drives keypad_scanner (DIV_BITS = 3, DEB_CNT = 2) from a behavioural
// keypad: a 4x4 matrix of pressed keys whose columns are pulled low only
// while the DUT drives that key's row. Expected key codes are queued when
// a press is issued and a monitor pops them on every key_valid pulse.
module tb_keypad_scanner;

    logic       clk;
    logic       reset_n;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    logic [3:0] keyMatrix [4];
    int         expQ [$];
    int         testsRun;
    int         testsFailed;
    int         edgeNum;
    logic       prevValid;
    logic       prevDown;

    // Spec key layout, indexed row*4 + col.
    int keyTable [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

    keypad_scanner #(
        .DIV_BITS (3),
        .DEB_CNT  (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Physical keypad: a pressed key shorts its column to its row line.
    always_comb begin
        logic [3:0] pulled;
        pulled = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (!row_n[i]) pulled = pulled | keyMatrix[i];
        end
        col_n = ~pulled;
    end

    // Rising edges since reset was released; sample points are the edges
    // whose number is a multiple of 8.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edgeNum <= 0;
        else          edgeNum <= edgeNum + 1;
    end

    function automatic logic [3:0] rowPattern(input int r);
        logic [3:0] one;
        one = 4'b0001 << (r % 4);
        return ~one;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int row, input logic [3:0] mask);
        keyMatrix[row] = mask;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitDown(input logic level, input int budget, input string name);
        int n;
        n = 0;
        while (key_down !== level && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, key_down, level);
    endtask

    task automatic waitRow(input logic [3:0] pattern, input int budget, input string name);
        int n;
        n = 0;
        while (row_n !== pattern && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, row_n, pattern);
    endtask

    // Monitor: every key_valid pulse must match the oldest queued press.
    always @(negedge clk) begin
        if (!reset_n) begin
            prevValid = 1'b0;
            prevDown  = 1'b0;
        end else begin
            if (key_valid) begin
                checkOutput("valid_back_to_back", prevValid, 1'b0);
                checkOutput("valid_while_down", prevDown, 1'b0);
                checkOutput("down_at_accept", key_down, 1'b1);
                if (expQ.size() == 0) begin
                    checkOutput("spurious_valid", key_valid, 1'b0);
                end else begin
                    int expCode;
                    expCode = expQ.pop_front();
                    checkOutput("key_code", key_code, expCode);
                end
            end
            prevValid = key_valid;
            prevDown  = key_down;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int e;
        int kf;
        int guard;
        int row;
        int col;

        testsRun    = 0;
        testsFailed = 0;
        prevValid   = 1'b0;
        prevDown    = 1'b0;
        for (int i = 0; i < 4; i++) keyMatrix[i] = 4'b0000;
        reset_n = 1'b0;
        waitCycles(2);

        // Reset values.
        checkOutput("reset_row_n", row_n, 4'b1110);
        checkOutput("reset_key_code", key_code, 4'h0);
        checkOutput("reset_key_valid", key_valid, 1'b0);
        checkOutput("reset_key_down", key_down, 1'b0);
        reset_n = 1'b1;

        // Idle: rows step every 8 cycles, no key activity.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checkOutput("idle_row", row_n, rowPattern(edgeNum / 8));
        end

        // Row 1 / column 2 held: code 6, row frozen while held.
        expQ.push_back(keyTable[1 * 4 + 2]);
        applyStimulus(1, 4'b0100);
        waitDown(1'b1, 200, "press_r1c2");
        for (int i = 0; i < 5; i++) begin
            waitCycles(20);
            checkOutput("held_row_frozen", row_n, 4'b1101);
            checkOutput("held_key_down", key_down, 1'b1);
        end

        // Release: key_down falls right after the 2nd settled all-ones sample.
        e = edgeNum;
        applyStimulus(1, 4'b0000);
        kf = ((e + 3 + 7) / 8) * 8 + 8;
        guard = 0;
        while (edgeNum < kf - 1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("release_before_fall", key_down, 1'b1);
        @(negedge clk);
        checkOutput("release_fall", key_down, 1'b0);
        checkOutput("release_row_resume", row_n, 4'b1011);
        checkOutput("release_code_held", key_code, 4'h6);

        // Bounce: key in row 0 seen at one sample point only.
        guard = 0;
        while (row_n === 4'b1110 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        waitRow(4'b1110, 40, "bounce_reach_row0");
        applyStimulus(0, 4'b0010);
        waitCycles(9);
        applyStimulus(0, 4'b0000);
        waitRow(4'b1101, 40, "bounce_row_advance");
        checkOutput("bounce_no_down", key_down, 1'b0);
        waitCycles(16);

        // Two columns low in row 3 are ignored; a single col3 gives D.
        applyStimulus(3, 4'b0011);
        waitCycles(80);
        checkOutput("double_col_ignored", key_down, 1'b0);
        expQ.push_back(keyTable[3 * 4 + 3]);
        applyStimulus(3, 4'b1000);
        waitDown(1'b1, 200, "press_r3c3");
        applyStimulus(3, 4'b0000);
        waitDown(1'b0, 200, "release_r3c3");

        // Reset while a key is held, then re-acceptance of the same key.
        expQ.push_back(keyTable[2 * 4 + 0]);
        applyStimulus(2, 4'b0001);
        waitDown(1'b1, 200, "press_r2c0");
        waitCycles(5);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midreset_row_n", row_n, 4'b1110);
        checkOutput("midreset_key_code", key_code, 4'h0);
        checkOutput("midreset_key_valid", key_valid, 1'b0);
        checkOutput("midreset_key_down", key_down, 1'b0);
        waitCycles(3);
        reset_n = 1'b1;
        expQ.push_back(keyTable[2 * 4 + 0]);
        waitDown(1'b1, 200, "repress_r2c0");
        applyStimulus(2, 4'b0000);
        waitDown(1'b0, 200, "release_r2c0");

        // Randomized single-key presses.
        for (int i = 0; i < 8; i++) begin
            row = $urandom_range(0, 3);
            col = $urandom_range(0, 3);
            expQ.push_back(keyTable[row * 4 + col]);
            applyStimulus(row, 4'b0001 << col);
            waitDown(1'b1, 200, "rand_press");
            waitCycles($urandom_range(5, 40));
            checkOutput("rand_held_row", row_n, rowPattern(row));
            applyStimulus(row, 4'b0000);
            waitDown(1'b0, 200, "rand_release");
            checkOutput("rand_next_row", row_n, rowPattern(row + 1));
            waitCycles($urandom_range(0, 20));
        end

        waitCycles(20);
        checkOutput("scoreboard_drain", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
